mem_port_arbiter: RTL and testbench

- Shares the single unified instruction/data memory of the multi-cycle MIPS32 core between two requesters.
  - Requester 0: the core's memory interface, driven by the control FSM's MemRead/MemWrite/IorD.
  - Requester 1: a program loader/debug port.
- Arbitrates requests, sequences a fixed-latency memory access and returns a one-cycle acknowledge.
- The core uses cpu_stall to hold its FSM state until its access completes.

---
 rtl/mem_port_arbiter_pkg.sv | 25 ++
 rtl/mem_port_arbiter.sv | 197 +++++++++++++++++++
 tb/tb_mem_port_arbiter.sv | 367 ++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_port_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module  : mem_port_arbiter_pkg
// Purpose : Shared encodings for the unified-memory port arbiter: FSM state
//           codes, grant identifiers and the latency counter width.
// Revision: 1.0 - initial release
// ============================================================================
package mem_port_arbiter_pkg;

  // Arbiter FSM states; code 2'd3 is unused and recovers to IDLE.
  typedef enum logic [1:0] {
    ARB_IDLE = 2'd0,
    ARB_BUSY = 2'd1,
    ARB_DONE = 2'd2
  } arb_state_e;

  // Requester identifiers as seen on the grant output.
  localparam logic GNT_CPU = 1'b0;
  localparam logic GNT_LD  = 1'b1;

  // Latency down-counter width; covers MEM_LAT up to 7.
  localparam int LAT_CNT_W = 3;

endpackage
`default_nettype wire

// File: rtl/mem_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module  : mem_port_arbiter
// Purpose : Shares one fixed-latency unified memory between the MIPS core
//           (requester 0) and a loader/debug port (requester 1). Round-robin
//           arbitration in IDLE, MEM_LAT BUSY cycles, one DONE cycle carrying
//           the winner's acknowledge.
// Revision: 1.0 - initial release
// ============================================================================
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int AW      = 32,
  parameter int DW      = 32,
  parameter int MEM_LAT = 1
) (
  input  logic          clk,
  input  logic          nrst,
  // core port
  input  logic          cpu_req,
  input  logic          cpu_we,
  input  logic [AW-1:0] cpu_addr,
  input  logic [DW-1:0] cpu_wdata,
  output logic [DW-1:0] cpu_rdata,
  output logic          cpu_ack,
  output logic          cpu_stall,
  // loader port
  input  logic          ld_req,
  input  logic          ld_we,
  input  logic [AW-1:0] ld_addr,
  input  logic [DW-1:0] ld_wdata,
  output logic [DW-1:0] ld_rdata,
  output logic          ld_ack,
  // memory port
  output logic          mem_re,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
  output logic          grant
);

  // Counter load value: MEM_LAT BUSY cycles means counting MEM_LAT-1 down to 0.
  localparam logic [LAT_CNT_W-1:0] LAT_INIT = LAT_CNT_W'(MEM_LAT - 1);

  arb_state_e           state_q, state_d;
  logic [LAT_CNT_W-1:0] lat_cnt_q, lat_cnt_d;
  logic                 grant_q, grant_d;
  logic                 last_grant_q, last_grant_d;
  logic                 mem_re_q, mem_re_d;
  logic                 mem_we_q, mem_we_d;
  logic [AW-1:0]        mem_addr_q, mem_addr_d;
  logic [DW-1:0]        mem_wdata_q, mem_wdata_d;
  logic [DW-1:0]        cpu_rdata_q, cpu_rdata_d;
  logic [DW-1:0]        ld_rdata_q, ld_rdata_d;
  logic                 cpu_ack_q, cpu_ack_d;
  logic                 ld_ack_q, ld_ack_d;

  // Arbitration: a lone requester wins; on a tie the one not served last wins.
  logic          any_req;
  logic          win;
  logic          win_we;
  logic [AW-1:0] win_addr;
  logic [DW-1:0] win_wdata;
  logic          busy_last;

  assign any_req   = cpu_req | ld_req;
  assign win       = (cpu_req && ld_req) ? ((last_grant_q == GNT_CPU) ? GNT_LD : GNT_CPU)
                                         : (ld_req ? GNT_LD : GNT_CPU);
  assign win_we    = (win == GNT_LD) ? ld_we    : cpu_we;
  assign win_addr  = (win == GNT_LD) ? ld_addr  : cpu_addr;
  assign win_wdata = (win == GNT_LD) ? ld_wdata : cpu_wdata;
  assign busy_last = (lat_cnt_q == '0);

  // Next-state and latency counter sequencing.
  always_comb begin
    state_d   = state_q;
    lat_cnt_d = lat_cnt_q;
    case (state_q)
      ARB_IDLE: begin
        if (any_req) begin
          state_d   = ARB_BUSY;
          lat_cnt_d = LAT_INIT;
        end
      end
      ARB_BUSY: begin
        if (busy_last) begin
          state_d = ARB_DONE;
        end else begin
          lat_cnt_d = lat_cnt_q - LAT_CNT_W'(1);
        end
      end
      ARB_DONE: begin
        state_d = ARB_IDLE;
      end
      default: begin
        state_d   = ARB_IDLE;
        lat_cnt_d = '0;
      end
    endcase
  end

  // Output and datapath next values; strobes and acks are registered.
  always_comb begin
    grant_d      = grant_q;
    last_grant_d = last_grant_q;
    mem_re_d     = mem_re_q;
    mem_we_d     = 1'b0;            // write strobe lives for one BUSY cycle only
    mem_addr_d   = mem_addr_q;
    mem_wdata_d  = mem_wdata_q;
    cpu_rdata_d  = cpu_rdata_q;
    ld_rdata_d   = ld_rdata_q;
    cpu_ack_d    = 1'b0;
    ld_ack_d     = 1'b0;
    case (state_q)
      ARB_IDLE: begin
        mem_re_d = 1'b0;
        if (any_req) begin
          grant_d      = win;
          last_grant_d = win;
          mem_addr_d   = win_addr;
          mem_wdata_d  = win_wdata;
          mem_re_d     = ~win_we;
          mem_we_d     = win_we;
        end
      end
      ARB_BUSY: begin
        if (busy_last) begin
          mem_re_d = 1'b0;
          // mem_re is only ever high during BUSY of a read, so it marks reads.
          if (mem_re_q) begin
            if (grant_q == GNT_LD) begin
              ld_rdata_d = mem_rdata;
            end else begin
              cpu_rdata_d = mem_rdata;
            end
          end
          if (grant_q == GNT_LD) begin
            ld_ack_d = 1'b1;
          end else begin
            cpu_ack_d = 1'b1;
          end
        end
      end
      ARB_DONE: begin
        mem_re_d = 1'b0;
      end
      default: begin
        mem_re_d = 1'b0;
      end
    endcase
  end

  // State and output registers; reset aborts any access in flight.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state_q      <= ARB_IDLE;
      lat_cnt_q    <= '0;
      grant_q      <= GNT_CPU;
      last_grant_q <= GNT_LD;       // core wins the first tie
      mem_re_q     <= 1'b0;
      mem_we_q     <= 1'b0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
      cpu_rdata_q  <= '0;
      ld_rdata_q   <= '0;
      cpu_ack_q    <= 1'b0;
      ld_ack_q     <= 1'b0;
    end else begin
      state_q      <= state_d;
      lat_cnt_q    <= lat_cnt_d;
      grant_q      <= grant_d;
      last_grant_q <= last_grant_d;
      mem_re_q     <= mem_re_d;
      mem_we_q     <= mem_we_d;
      mem_addr_q   <= mem_addr_d;
      mem_wdata_q  <= mem_wdata_d;
      cpu_rdata_q  <= cpu_rdata_d;
      ld_rdata_q   <= ld_rdata_d;
      cpu_ack_q    <= cpu_ack_d;
      ld_ack_q     <= ld_ack_d;
    end
  end

  assign grant     = grant_q;
  assign mem_re    = mem_re_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign cpu_rdata = cpu_rdata_q;
  assign ld_rdata  = ld_rdata_q;
  assign cpu_ack   = cpu_ack_q;
  assign ld_ack    = ld_ack_q;
  assign cpu_stall = cpu_req & ~cpu_ack_q;

endmodule
`default_nettype wire

// File: tb/tb_mem_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module  : tb_mem_port_arbiter
// Purpose : Self-checking bench. Two arbiters (MEM_LAT=1 and MEM_LAT=3), each
//           with its own memory model, driven by directed scenarios and then
//           protocol-respecting random traffic, compared every cycle against
//           a transaction-timeline reference model.
// Revision: 1.0 - initial release
// ============================================================================
module tb_mem_port_arbiter;

  localparam int NW = 32;  // words in each memory model

  logic clk = 1'b0;
  logic nrst;
  always #5 clk = ~clk;

  logic        cpu_req [2];
  logic        cpu_we  [2];
  logic [31:0] cpu_addr[2];
  logic [31:0] cpu_wdata[2];
  logic [31:0] cpu_rdata[2];
  logic        cpu_ack [2];
  logic        cpu_stall[2];
  logic        ld_req  [2];
  logic        ld_we   [2];
  logic [31:0] ld_addr [2];
  logic [31:0] ld_wdata[2];
  logic [31:0] ld_rdata[2];
  logic        ld_ack  [2];
  logic        mem_re  [2];
  logic        mem_we  [2];
  logic [31:0] mem_addr[2];
  logic [31:0] mem_wdata[2];
  logic [31:0] mem_rdata[2];
  logic        grant   [2];

  mem_port_arbiter #(.AW(32), .DW(32), .MEM_LAT(1)) u_dut0 (
    .clk(clk), .nrst(nrst),
    .cpu_req(cpu_req[0]), .cpu_we(cpu_we[0]), .cpu_addr(cpu_addr[0]), .cpu_wdata(cpu_wdata[0]),
    .cpu_rdata(cpu_rdata[0]), .cpu_ack(cpu_ack[0]), .cpu_stall(cpu_stall[0]),
    .ld_req(ld_req[0]), .ld_we(ld_we[0]), .ld_addr(ld_addr[0]), .ld_wdata(ld_wdata[0]),
    .ld_rdata(ld_rdata[0]), .ld_ack(ld_ack[0]),
    .mem_re(mem_re[0]), .mem_we(mem_we[0]), .mem_addr(mem_addr[0]), .mem_wdata(mem_wdata[0]),
    .mem_rdata(mem_rdata[0]), .grant(grant[0])
  );

  mem_port_arbiter #(.AW(32), .DW(32), .MEM_LAT(3)) u_dut1 (
    .clk(clk), .nrst(nrst),
    .cpu_req(cpu_req[1]), .cpu_we(cpu_we[1]), .cpu_addr(cpu_addr[1]), .cpu_wdata(cpu_wdata[1]),
    .cpu_rdata(cpu_rdata[1]), .cpu_ack(cpu_ack[1]), .cpu_stall(cpu_stall[1]),
    .ld_req(ld_req[1]), .ld_we(ld_we[1]), .ld_addr(ld_addr[1]), .ld_wdata(ld_wdata[1]),
    .ld_rdata(ld_rdata[1]), .ld_ack(ld_ack[1]),
    .mem_re(mem_re[1]), .mem_we(mem_we[1]), .mem_addr(mem_addr[1]), .mem_wdata(mem_wdata[1]),
    .mem_rdata(mem_rdata[1]), .grant(grant[1])
  );

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string nm, input int k, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s[dut%0d] @%0t: got 0x%0h, expected 0x%0h", nm, k, $time, act, exp);
    end
  endtask

  function automatic int lat_of(input int k);
    return (k == 0) ? 1 : 3;
  endfunction

  function automatic logic [31:0] init_word(input int k, input int i);
    if (k == 0 && i == 4) return 32'hDEADBEEF;
    if (k == 1 && i == 5) return 32'hA5A50F0F;
    return 32'h5000_0000 | (32'(k) << 8) | 32'(i);
  endfunction

  // ---------------- memory models (react to DUT strobes) ----------------
  logic [31:0] mem [2][NW];
  int          re_cnt[2];

  // Data is only valid on the MEM_LAT-th cycle of mem_re; junk otherwise.
  assign mem_rdata[0] = (re_cnt[0] == 1) ? mem[0][mem_addr[0][6:2]] : (32'hBAD0_0000 | 32'(re_cnt[0]));
  assign mem_rdata[1] = (re_cnt[1] == 3) ? mem[1][mem_addr[1][6:2]] : (32'hBAD0_0000 | 32'(re_cnt[1]));

  initial begin
    for (int k = 0; k < 2; k++) begin
      re_cnt[k] = 0;
      for (int i = 0; i < NW; i++) mem[k][i] = init_word(k, i);
    end
    forever begin
      @(negedge clk);
      for (int k = 0; k < 2; k++) begin
        re_cnt[k] = mem_re[k] ? re_cnt[k] + 1 : 0;
        if (mem_we[k]) mem[k][mem_addr[k][6:2]] = mem_wdata[k];
      end
    end
  end

  // ---------------- reference model: transaction timeline ----------------
  logic [31:0] ref_mem [2][NW];
  int          m_e[2], m_g[2];
  bit          m_act[2], m_own[2], m_last[2], m_we[2];
  logic [31:0] m_addr[2];
  bit          x_re[2], x_we[2], x_cack[2], x_lack[2], x_grant[2];
  logic [31:0] x_addr[2], x_wd[2], x_crd[2], x_lrd[2];

  task automatic model_reset(input int k);
    m_e[k] = 0; m_g[k] = 0; m_act[k] = 0; m_own[k] = 0; m_last[k] = 1; m_we[k] = 0;
    m_addr[k] = '0;
    x_re[k] = 0; x_we[k] = 0; x_cack[k] = 0; x_lack[k] = 0; x_grant[k] = 0;
    x_addr[k] = '0; x_wd[k] = '0; x_crd[k] = '0; x_lrd[k] = '0;
  endtask

  task automatic model_step(input int k);
    int d;
    m_e[k]++;
    // Port is free again once BUSY(lat)+DONE+one IDLE cycle have elapsed.
    if (!m_act[k] || m_e[k] >= m_g[k] + lat_of(k) + 2) begin
      m_act[k] = 0;
      if (cpu_req[k] || ld_req[k]) begin
        m_own[k]  = (cpu_req[k] && ld_req[k]) ? !m_last[k] : ld_req[k];
        m_last[k] = m_own[k];
        m_act[k]  = 1;
        m_g[k]    = m_e[k];
        m_we[k]   = m_own[k] ? ld_we[k] : cpu_we[k];
        m_addr[k] = m_own[k] ? ld_addr[k] : cpu_addr[k];
        x_grant[k] = m_own[k];
        x_addr[k]  = m_addr[k];
        x_wd[k]    = m_own[k] ? ld_wdata[k] : cpu_wdata[k];
        if (m_we[k]) ref_mem[k][m_addr[k][6:2]] = x_wd[k];
      end
    end
    x_re[k] = 0; x_we[k] = 0; x_cack[k] = 0; x_lack[k] = 0;
    if (m_act[k]) begin
      d = m_e[k] - m_g[k];
      if (d < lat_of(k)) begin
        x_re[k] = !m_we[k];
        x_we[k] = m_we[k] && (d == 0);
      end else if (d == lat_of(k)) begin
        if (m_own[k]) x_lack[k] = 1; else x_cack[k] = 1;
        if (!m_we[k]) begin
          if (m_own[k]) x_lrd[k] = ref_mem[k][m_addr[k][6:2]];
          else          x_crd[k] = ref_mem[k][m_addr[k][6:2]];
        end
      end
    end
  endtask

  initial begin
    for (int k = 0; k < 2; k++)
      for (int i = 0; i < NW; i++) ref_mem[k][i] = init_word(k, i);
    forever begin
      @(posedge clk or negedge nrst);
      for (int k = 0; k < 2; k++) begin
        if (!nrst) model_reset(k);
        else       model_step(k);
      end
    end
  end

  // ---------------- per-cycle comparison ----------------
  initial begin
    forever begin
      @(negedge clk);
      for (int k = 0; k < 2; k++) begin
        chk("mem_re",    k, mem_re[k],    x_re[k]);
        chk("mem_we",    k, mem_we[k],    x_we[k]);
        chk("mem_addr",  k, mem_addr[k],  x_addr[k]);
        chk("mem_wdata", k, mem_wdata[k], x_wd[k]);
        chk("cpu_ack",   k, cpu_ack[k],   x_cack[k]);
        chk("ld_ack",    k, ld_ack[k],    x_lack[k]);
        chk("cpu_rdata", k, cpu_rdata[k], x_crd[k]);
        chk("ld_rdata",  k, ld_rdata[k],  x_lrd[k]);
        chk("grant",     k, grant[k],     x_grant[k]);
        chk("cpu_stall", k, cpu_stall[k], cpu_req[k] & ~x_cack[k]);
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    @(negedge clk);
    #2;
  endtask

  task automatic wait_ack(input int k, input bit who, output int ticks, output int nre,
                          output int nwe, output logic [31:0] wa, output logic [31:0] wd);
    bit got;
    got = 0; ticks = 0; nre = 0; nwe = 0; wa = '0; wd = '0;
    while (!got && ticks < 30) begin
      tick();
      ticks++;
      if (mem_re[k]) nre++;
      if (mem_we[k]) begin nwe++; wa = mem_addr[k]; wd = mem_wdata[k]; end
      got = who ? ld_ack[k] : cpu_ack[k];
      if (!who && cpu_req[k]) chk("stall_level", k, cpu_stall[k], !got);
    end
    chk("ack_seen", k, got, 1);
    if (who) ld_req[k] = 0; else cpu_req[k] = 0;
  endtask

  task automatic new_access(input int k, input bit r);
    logic [31:0] a;
    a = {25'd0, 5'($urandom_range(0, NW - 1)), 2'b00};
    if (r) begin
      ld_req[k] = 1; ld_we[k] = 1'($urandom_range(0, 1)); ld_addr[k] = a; ld_wdata[k] = $urandom;
    end else begin
      cpu_req[k] = 1; cpu_we[k] = 1'($urandom_range(0, 1)); cpu_addr[k] = a; cpu_wdata[k] = $urandom;
    end
  endtask

  task automatic drive_random(input int k, input bit r);
    bit req, ack;
    req = r ? ld_req[k] : cpu_req[k];
    ack = r ? ld_ack[k] : cpu_ack[k];
    if (req && ack) begin
      if ($urandom_range(0, 1) == 1) new_access(k, r);
      else if (r) ld_req[k] = 0; else cpu_req[k] = 0;
    end else if (req) begin
      if ($urandom_range(0, 23) == 0) begin
        if (r) ld_req[k] = 0; else cpu_req[k] = 0;
      end
    end else if ($urandom_range(0, 2) == 0) begin
      new_access(k, r);
    end
  endtask

  task automatic reset_pulse();
    nrst = 0;
    tick();
    tick();
    nrst = 1;
    tick();
  endtask

  // ---------------- main sequence ----------------
  int          t, nre, nwe, nack;
  logic [31:0] wa, wd;
  logic [3:0]  gseq;
  bit          prev, now;

  initial begin
    nrst = 0;
    for (int k = 0; k < 2; k++) begin
      cpu_req[k] = 0; cpu_we[k] = 0; cpu_addr[k] = '0; cpu_wdata[k] = '0;
      ld_req[k]  = 0; ld_we[k]  = 0; ld_addr[k]  = '0; ld_wdata[k]  = '0;
    end
    tick();
    tick();
    // reset state, literal
    chk("rst_mem_re", 0, mem_re[0], 0);
    chk("rst_grant",  0, grant[0], 0);
    chk("rst_addr",   1, mem_addr[1], 0);
    chk("rst_ack",    1, {cpu_ack[1], ld_ack[1]}, 0);
    nrst = 1;
    tick();

    // core read, MEM_LAT=1
    cpu_we[0] = 0; cpu_addr[0] = 32'h10; cpu_req[0] = 1;
    wait_ack(0, 0, t, nre, nwe, wa, wd);
    chk("rd1_latency", 0, t, 2);
    chk("rd1_re_cycles", 0, nre, 1);
    chk("rd1_data", 0, cpu_rdata[0], 32'hDEADBEEF);
    tick();

    // loader write
    ld_we[0] = 1; ld_addr[0] = 32'h40; ld_wdata[0] = 32'h12345678; ld_req[0] = 1;
    wait_ack(0, 1, t, nre, nwe, wa, wd);
    chk("wr_latency", 0, t, 2);
    chk("wr_we_pulses", 0, nwe, 1);
    chk("wr_re_cycles", 0, nre, 0);
    chk("wr_addr", 0, wa, 32'h40);
    chk("wr_data", 0, wd, 32'h12345678);
    chk("wr_grant", 0, grant[0], 1);
    chk("wr_ld_rdata", 0, ld_rdata[0], 0);
    tick();
    chk("wr_mem_cell", 0, mem[0][16], 32'h12345678);

    // core read, MEM_LAT=3
    cpu_we[1] = 0; cpu_addr[1] = 32'h14; cpu_req[1] = 1;
    wait_ack(1, 0, t, nre, nwe, wa, wd);
    chk("rd3_latency", 1, t, 4);
    chk("rd3_re_cycles", 1, nre, 3);
    chk("rd3_data", 1, cpu_rdata[1], 32'hA5A50F0F);
    tick();

    // both requesting from reset, held continuously
    reset_pulse();
    cpu_we[0] = 0; cpu_addr[0] = 32'h10; cpu_req[0] = 1;
    ld_we[0]  = 0; ld_addr[0]  = 32'h14; ld_req[0]  = 1;
    nack = 0; prev = 0; gseq = '0;
    for (int i = 0; i < 40 && nack < 4; i++) begin
      tick();
      now = cpu_ack[0] | ld_ack[0];
      if (now) begin
        chk("alt_dual_ack", 0, cpu_ack[0] & ld_ack[0], 0);
        chk("alt_isolated", 0, prev, 0);
        gseq[nack] = grant[0];
        nack++;
      end
      prev = now;
    end
    chk("alt_count", 0, nack, 4);
    chk("alt_seq", 0, gseq, 4'b1010);
    cpu_req[0] = 0; ld_req[0] = 0;
    tick();
    tick();

    // reset during BUSY of a loader read, core request pending
    ld_we[1] = 0; ld_addr[1] = 32'h08; ld_req[1] = 1;
    tick();
    tick();
    chk("rst_mid_busy", 1, mem_re[1], 1);
    cpu_we[1] = 0; cpu_addr[1] = 32'h14; cpu_req[1] = 1;
    nrst = 0;
    #1;
    chk("abort_re",    1, mem_re[1], 0);
    chk("abort_grant", 1, grant[1], 0);
    chk("abort_addr",  1, mem_addr[1], 0);
    chk("abort_rdata", 1, cpu_rdata[1], 0);
    tick();
    chk("abort_no_ack", 1, ld_ack[1], 0);
    nrst = 1;
    tick();
    chk("post_rst_grant", 1, grant[1], 0);
    chk("post_rst_re",    1, mem_re[1], 1);
    wait_ack(1, 0, t, nre, nwe, wa, wd);
    chk("post_rst_cpu_data", 1, cpu_rdata[1], 32'hA5A50F0F);
    wait_ack(1, 1, t, nre, nwe, wa, wd);
    chk("post_rst_ld_data", 1, ld_rdata[1], 32'h5000_0102);
    tick();

    // core drops request mid-BUSY
    cpu_we[1] = 0; cpu_addr[1] = 32'h00; cpu_req[1] = 1;
    tick();
    tick();
    cpu_req[1] = 0;
    nack = 0; nre = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (cpu_ack[1]) nack++;
      if (mem_re[1]) nre++;
    end
    chk("drop_acks", 1, nack, 1);
    chk("drop_no_regrant", 1, nre, 1);

    // random traffic on both arbiters
    for (int i = 0; i < 1500; i++) begin
      tick();
      for (int k = 0; k < 2; k++) begin
        drive_random(k, 0);
        drive_random(k, 1);
      end
    end
    for (int k = 0; k < 2; k++) begin
      cpu_req[k] = 0; ld_req[k] = 0;
    end
    repeat (8) tick();

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
`default_nettype wire
